// File: rtl/fft_twiddle_mul.sv
// Twiddle-factor multiplier feeding an FFT butterfly: rotates B by a complex twiddle,
// rounds and saturates the result, and passes A alongside it through a 2-stage elastic pipeline.
module fft_twiddle_mul #(
  parameter int LAST_WIDTH = 12,
  parameter int TW_WIDTH   = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [LAST_WIDTH:0]   a_re,
  input  logic signed [LAST_WIDTH:0]   a_im,
  input  logic signed [LAST_WIDTH:0]   b_re,
  input  logic signed [LAST_WIDTH:0]   b_im,
  input  logic signed [TW_WIDTH-1:0]   tw_re,
  input  logic signed [TW_WIDTH-1:0]   tw_im,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         bf_en,
  output logic signed [LAST_WIDTH:0]   Re_a,
  output logic signed [LAST_WIDTH:0]   Im_a,
  output logic signed [LAST_WIDTH-1:0] Re_b,
  output logic signed [LAST_WIDTH-1:0] Im_b,
  input  logic                         sat_clr,
  output logic [7:0]                   sat_cnt
);

  localparam int XW = LAST_WIDTH + 1 + TW_WIDTH;
  localparam int PW = LAST_WIDTH + TW_WIDTH + 2;
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (TW_WIDTH - 3));
  localparam logic signed [PW-1:0] SMAX = PW'(2 ** (LAST_WIDTH - 1) - 1);
  localparam logic signed [PW-1:0] SMIN = ~SMAX;

  logic                       s1_valid_q, s1_valid_d;
  logic                       s2_valid_q, s2_valid_d;
  logic                       s1_load, s2_load, s1_en, s2_en;
  logic signed [XW-1:0]       rr_d, ii_d, ri_d, ir_d;
  logic signed [XW-1:0]       rr_q, ii_q, ri_q, ir_q;
  logic signed [LAST_WIDTH:0] s1_are_q, s1_aim_q;
  logic signed [LAST_WIDTH:0] s2_are_q, s2_aim_q;
  logic signed [LAST_WIDTH-1:0] s2_reb_q, s2_imb_q;
  logic signed [PW-1:0]       pre_d, pim_d;
  logic [LAST_WIDTH:0]        re_rs_d, im_rs_d;
  logic [7:0]                 sat_cnt_q, sat_cnt_d;

  // Returns {saturated, value}: round half up at the unity scale, then clamp to LAST_WIDTH bits.
  function automatic logic [LAST_WIDTH:0] roundSat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    logic                 hit;
    s   = (p + RND) >>> (TW_WIDTH - 2);
    hit = 1'b0;
    if (s > SMAX) begin
      s   = SMAX;
      hit = 1'b1;
    end else if (s < SMIN) begin
      s   = SMIN;
      hit = 1'b1;
    end
    return {hit, s[LAST_WIDTH-1:0]};
  endfunction

  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    s1_load    = !s1_valid_q || s2_load;
    s1_en      = s1_load && in_valid;
    s2_en      = s2_load && s1_valid_q;
    s1_valid_d = s1_load ? in_valid : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

    rr_d = b_re * tw_re;
    ii_d = b_im * tw_im;
    ri_d = b_re * tw_im;
    ir_d = b_im * tw_re;

    pre_d   = PW'(rr_q) - PW'(ii_q);
    pim_d   = PW'(ri_q) + PW'(ir_q);
    re_rs_d = roundSat(pre_d);
    im_rs_d = roundSat(pim_d);

    // Clear has priority; the counter sticks at its maximum instead of wrapping.
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)
      sat_cnt_d = 8'd0;
    else if (s2_en && (re_rs_d[LAST_WIDTH] || im_rs_d[LAST_WIDTH]) && sat_cnt_q != 8'hFF)
      sat_cnt_d = sat_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      rr_q       <= '0;
      ii_q       <= '0;
      ri_q       <= '0;
      ir_q       <= '0;
      s1_are_q   <= '0;
      s1_aim_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_en) begin
        rr_q     <= rr_d;
        ii_q     <= ii_d;
        ri_q     <= ri_d;
        ir_q     <= ir_d;
        s1_are_q <= a_re;
        s1_aim_q <= a_im;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_are_q   <= '0;
      s2_aim_q   <= '0;
      s2_reb_q   <= '0;
      s2_imb_q   <= '0;
      sat_cnt_q  <= 8'd0;
    end else begin
      s2_valid_q <= s2_valid_d;
      sat_cnt_q  <= sat_cnt_d;
      if (s2_en) begin
        s2_are_q <= s1_are_q;
        s2_aim_q <= s1_aim_q;
        s2_reb_q <= re_rs_d[LAST_WIDTH-1:0];
        s2_imb_q <= im_rs_d[LAST_WIDTH-1:0];
      end
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign bf_en     = s2_valid_q;
  assign Re_a      = s2_are_q;
  assign Im_a      = s2_aim_q;
  assign Re_b      = s2_reb_q;
  assign Im_b      = s2_imb_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_fft_twiddle_mul.sv
// Scoreboard bench for fft_twiddle_mul: directed vectors push expected beats, a negedge
// monitor pops and compares every output transfer.
module tb_fft_twiddle_mul;
  localparam int LW = 12;
  localparam int TW = 10;

  typedef struct packed { int ar; int ai; int br; int bi; } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [LW:0]   a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic signed [TW-1:0] tw_re = '0, tw_im = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 bf_en;
  logic signed [LW:0]   Re_a, Im_a;
  logic signed [LW-1:0] Re_b, Im_b;
  logic                 sat_clr = 1'b0;
  logic [7:0]           sat_cnt;

  exp_t expQ[$];
  int   checkCount = 0;
  int   failCount = 0;
  bit   randReady = 1'b0;

  fft_twiddle_mul #(.LAST_WIDTH(LW), .TW_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .tw_re(tw_re), .tw_im(tw_im), .out_valid(out_valid), .out_ready(out_ready),
    .bf_en(bf_en), .Re_a(Re_a), .Im_a(Im_a), .Re_b(Re_b), .Im_b(Im_b),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int req);
    checkCount++;
    if (act != req) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference rotation: exact integer product, round half up, clamp to LW bits.
  task automatic modelRot(input int br, bi, tr, ti, output int er, ei);
    int pr, pi;
    pr = br * tr - bi * ti;
    pi = br * ti + bi * tr;
    er = (pr + 128) >>> 8;
    ei = (pi + 128) >>> 8;
    if (er > 2047) er = 2047;
    if (er < -2048) er = -2048;
    if (ei > 2047) ei = 2047;
    if (ei < -2048) ei = -2048;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the vector.
  task automatic applyStimulus(input int ar, ai, br, bi, tr, ti, ebr, ebi);
    int n;
    exp_t e;
    a_re = (LW+1)'(ar); a_im = (LW+1)'(ai);
    b_re = (LW+1)'(br); b_im = (LW+1)'(bi);
    tw_re = TW'(tr);    tw_im = TW'(ti);
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) begin
        checkOutput("acceptTimeout", 0, 1);
        break;
      end
    end
    if (in_ready) begin
      e = '{ar: ar, ai: ai, br: ebr, bi: ebi};
      expQ.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drainEmpty", expQ.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checkOutput("bf_en", int'(bf_en), 1);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBeat", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("Re_a", int'(Re_a), e.ar);
          checkOutput("Im_a", int'(Im_a), e.ai);
          checkOutput("Re_b", int'(Re_b), e.br);
          checkOutput("Im_b", int'(Im_b), e.bi);
        end
      end
    end
  end

  initial begin : readyToggler
    forever begin
      @(posedge clk); #1;
      if (randReady) out_ready = 1'($urandom_range(1));
    end
  end

  initial begin : stimulus
    int er, ei, accepts, idx, n;
    int snapRb, snapIb, snapRa;
    int br, bi, tr, ti;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstOutValid", int'(out_valid), 0);
    checkOutput("rstSatCnt", int'(sat_cnt), 0);
    checkOutput("rstReB", int'(Re_b), 0);
    checkOutput("rstReA", int'(Re_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstInReady", int'(in_ready), 1);

    // Identity rotation plus latency and single-cycle bf_en
    applyStimulus(7, -3, 100, -50, 256, 0, 100, -50);
    @(negedge clk); checkOutput("latCycle1", int'(out_valid), 0);
    @(negedge clk); checkOutput("latCycle2", int'(out_valid), 1);
    @(negedge clk); checkOutput("bfEnOneCycle", int'(bf_en), 0);
    @(posedge clk); #1;

    applyStimulus(1, 2, 100, -50, 0, -256, -50, -100);
    applyStimulus(0, 0, 1, 0, 128, 0, 1, 0);
    applyStimulus(0, 0, -1, 0, 128, 0, 0, 0);
    applyStimulus(0, 0, -3, 0, 128, 0, -1, 0);
    waitDrain();
    checkOutput("noSatYet", int'(sat_cnt), 0);

    applyStimulus(5, 5, 4095, 4095, 181, -181, 2047, 0);
    waitDrain();
    checkOutput("satCnt1", int'(sat_cnt), 1);
    for (int i = 0; i < 299; i++) applyStimulus(i, -i, 4095, 4095, 181, -181, 2047, 0);
    waitDrain();
    checkOutput("satCntStick", int'(sat_cnt), 255);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    checkOutput("satClr", int'(sat_cnt), 0);
    @(posedge clk); #1;
    // Clear held across the edge where a saturating beat loads S2
    applyStimulus(9, 9, 4095, 4095, 181, -181, 2047, 0);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    waitDrain();
    checkOutput("satClrWins", int'(sat_cnt), 0);

    // Backpressure: 4 cycles of stall while 4 vectors are offered
    out_ready = 1'b0;
    accepts = 0;
    idx = 0;
    snapRb = 0; snapIb = 0; snapRa = 0;
    a_re = 13'(0); a_im = 13'(0); b_re = 13'(10); b_im = -13'sd20;
    tw_re = 10'sd256; tw_im = 10'sd0;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back('{ar: idx, ai: -idx, br: 10 + idx, bi: -20 - idx});
        accepts++;
        idx++;
      end
      if (c == 2) begin
        snapRb = int'(Re_b); snapIb = int'(Im_b); snapRa = int'(Re_a);
      end
      if (c == 3) begin
        checkOutput("bpInReady", int'(in_ready), 0);
        checkOutput("bpStableReB", int'(Re_b), snapRb);
        checkOutput("bpStableImB", int'(Im_b), snapIb);
        checkOutput("bpStableReA", int'(Re_a), snapRa);
        checkOutput("bpOutValid", int'(out_valid), 1);
      end
      @(posedge clk); #1;
      a_re = 13'(idx); a_im = 13'(-idx); b_re = 13'(10 + idx); b_im = 13'(-20 - idx);
    end
    checkOutput("bpAccepts", accepts, 2);
    out_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back('{ar: idx, ai: -idx, br: 10 + idx, bi: -20 - idx});
        idx++;
      end
      @(posedge clk); #1;
      a_re = 13'(idx); a_im = 13'(-idx); b_re = 13'(10 + idx); b_im = 13'(-20 - idx);
      n++;
    end
    in_valid = 1'b0;
    checkOutput("bpAllOffered", idx, 4);
    waitDrain();

    // Random valid/ready against the reference model
    randReady = 1'b1;
    for (int i = 0; i < 150; i++) begin
      br = int'($urandom_range(8191)) - 4096;
      bi = int'($urandom_range(8191)) - 4096;
      tr = int'($urandom_range(1023)) - 512;
      ti = int'($urandom_range(1023)) - 512;
      modelRot(br, bi, tr, ti, er, ei);
      applyStimulus(i, 100 - i, br, bi, tr, ti, er, ei);
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
    end
    randReady = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    waitDrain();

    // Reset with both stages full
    out_ready = 1'b0;
    applyStimulus(1, 1, 1, 1, 256, 0, 1, 1);
    applyStimulus(2, 2, 2, 2, 256, 0, 2, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstOutValid", int'(out_valid), 0);
    checkOutput("midRstBfEn", int'(bf_en), 0);
    checkOutput("midRstReB", int'(Re_b), 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("postRstInReady", int'(in_ready), 1);
    repeat (6) @(negedge clk);
    checkOutput("postRstNoBeat", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule

// File: doc/fft_twiddle_mul.md
FFT_TWIDDLE_MUL -- requirements
Module: fft_twiddle_mul

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- LAST_WIDTH, 12, butterfly output width; B-operand output is LAST_WIDTH bits, A-operand is LAST_WIDTH+1 bits.
- TW_WIDTH, 10, signed twiddle width; unity = 2^(TW_WIDTH-2).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input operand set valid.
- in_ready, out, 1, block accepts input this cycle.
- a_re / a_im, in, LAST_WIDTH+1 signed, A operand (passed through, delay-aligned).
- b_re / b_im, in, LAST_WIDTH+1 signed, B operand to be rotated.
- tw_re / tw_im, in, TW_WIDTH signed, twiddle cos / -sin from external ROM, sampled with in_valid.
- out_valid, out, 1, output set valid.
- out_ready, in, 1, downstream butterfly/memory accepts output.
- bf_en, out, 1, butterfly enable; equals out_valid.
- Re_a / Im_a, out, LAST_WIDTH+1 signed, delayed A operand.
- Re_b / Im_b, out, LAST_WIDTH signed, rotated, rounded, saturated B operand.
- sat_clr, in, 1, synchronous clear of sat_cnt.
- sat_cnt, out, 8, saturation event counter.

Function
REQ-003 The block shall rotate B by the twiddle: P_re = b_re*tw_re - b_im*tw_im; P_im = b_re*tw_im + b_im*tw_re, at full precision (LAST_WIDTH+TW_WIDTH+2 bits, no intermediate overflow).
REQ-004 Scaling: add 2^(TW_WIDTH-3), then arithmetic shift right by TW_WIDTH-2 (round half toward +inf).
REQ-005 Saturation: clamp the scaled result to [-2^(LAST_WIDTH-1), 2^(LAST_WIDTH-1)-1] independently for re and im.
REQ-006 Pipeline: stage S1 registers the four products plus the A operand; stage S2 registers the rounded, saturated B result plus the A operand; latency from accept to out_valid = 2 cycles.
REQ-007 Handshake: input transfers when in_valid && in_ready; output transfers when out_valid && out_ready.
REQ-008 Stage advance: s2_load = !s2_valid || out_ready; s1_load = !s1_valid || s2_load; in_ready = s1_load (combinational, no dependence on in_valid).
REQ-009 Bubbles shall collapse: an empty S1 accepts input even while S2 is stalled.
REQ-010 Outputs and all data registers shall hold stable while out_valid && !out_ready.
REQ-011 A and B results of one accepted input shall always emerge in the same output beat, in acceptance order; no drop, no duplication.
REQ-012 sat_cnt shall increment by 1 for each S2 load in which re or im (or both) saturated, counting one per beat; it shall stick at 255 and not wrap.
REQ-013 If sat_clr and a saturation event occur in the same cycle, sat_clr wins and sat_cnt = 0.
REQ-014 Data registers shall not toggle when their stage does not load (power).

Reset
REQ-015 On rst_n low, asynchronously: s1_valid = s2_valid = 0, out_valid = bf_en = 0, sat_cnt = 0, and Re_a, Im_a, Re_b, Im_b = 0.
REQ-016 After reset, in_ready = 1 in the first cycle.
REQ-017 Reset asserted mid-operation shall discard all in-flight data; no output beat appears for those inputs after release.

Verification
REQ-018 Identity: TW_WIDTH=10, tw = (256, 0), b = (100, -50), a = (7, -3), out_ready = 1 -> 2 cycles later (Re_b, Im_b) = (100, -50), (Re_a, Im_a) = (7, -3), bf_en = 1 for one cycle.
REQ-019 -j rotation: tw = (0, -256), b = (100, -50) -> (Re_b, Im_b) = (-50, -100).
REQ-020 Rounding: tw = (128, 0) with b = (1, 0) -> Re_b = 1; b = (-1, 0) -> Re_b = 0; b = (-3, 0) -> Re_b = -1.
REQ-021 Saturation: tw = (181, -181), b = (4095, 4095) -> Re_b = 2047, Im_b = 0, sat_cnt increments 0 -> 1; 300 such beats -> sat_cnt = 255; sat_clr pulse -> sat_cnt = 0.
REQ-022 Backpressure: out_ready = 0 for 4 cycles while 4 back-to-back inputs are offered -> exactly 2 accepted, then in_ready = 0 with outputs stable; after out_ready = 1, all inputs emerge in order with none lost; random valid/ready run checked against a reference model.
REQ-023 Reset mid-stream: assert rst_n = 0 with S1 and S2 full -> out_valid = 0 immediately, no stale beat after release, in_ready = 1.
